// File: rtl/uart_pkg.sv
// Shared types and constants for the UART receive path.
package uart_pkg;

    // 100 MHz aclk / 115200 baud
    localparam int CLKS_PER_BIT_DEF = 868;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        START = 3'd1,
        DATA  = 3'd2,
        STOP  = 3'd3,
        BREAK = 3'd4
    } state_t;

endpackage

// File: rtl/uart_rx_if.sv
// Single-beat AXI4-Stream byte channel from the UART receiver to the framer.
interface uart_rx_if;
    logic       tvalid;
    logic       tready;
    logic [7:0] tdata;

    modport master (
        output tvalid,
        output tdata,
        input  tready
    );

    modport slave (
        input  tvalid,
        input  tdata,
        output tready
    );
endinterface

// File: rtl/sync_2ff.sv
// Generic single-bit two-flop synchronizer with a selectable reset value.
module sync_2ff #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_d,
    output logic o_q
);
    logic r_meta;
    logic r_sync;

    // Two back-to-back flops; the first may go metastable, the second settles it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_meta <= RST_VAL;
            r_sync <= RST_VAL;
        end else begin
            r_meta <= i_d;
            r_sync <= r_meta;
        end
    end

    assign o_q = r_sync;
endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver with mid-bit sampling and an AXI4-Stream byte output.
//
//   state | meaning
//   ------+------------------------------------------------------------
//   IDLE  | line idle, waiting for a low level on the synchronized line
//   START | half-bit wait, then confirm the start bit is still low
//   DATA  | sample eight data bits, LSB first, one per bit period
//   STOP  | sample the stop bit, deliver the byte or flag a framing error
//   BREAK | line held low after a bad stop bit, wait for it to go high
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF
) (
    input  logic      aclk,
    input  logic      areset,
    input  logic      uart_rxd,
    uart_rx_if.master rxbyte,
    output logic      frame_error,
    output logic      overrun
);
    localparam int            CW       = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BIT_END  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);

    state_t        r_state;
    state_t        w_state_nxt;
    logic [CW-1:0] r_cnt;
    logic [2:0]    r_idx;
    logic [7:0]    r_shift;
    logic          r_tvalid;
    logic [7:0]    r_tdata;
    logic          r_frame_error;
    logic          r_overrun;

    logic          w_rxd_s;
    logic          w_cnt_run;
    logic          w_cnt_clr;
    logic          w_shift_en;
    logic          w_stop_ok;
    logic          w_stop_bad;
    logic          w_enter_data;
    logic          w_xfer;
    logic          w_load;

    sync_2ff #(
        .RST_VAL (1'b1)
    ) u_sync_rxd (
        .i_clk (aclk),
        .i_rst (areset),
        .i_d   (uart_rxd),
        .o_q   (w_rxd_s)
    );

    // State register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode and per-cycle sampling strobes.
    always_comb begin
        w_state_nxt  = r_state;
        w_cnt_run    = 1'b0;
        w_shift_en   = 1'b0;
        w_stop_ok    = 1'b0;
        w_stop_bad   = 1'b0;
        w_enter_data = 1'b0;
        w_cnt_clr    = 1'b0;
        case (r_state)
            IDLE: begin
                if (!w_rxd_s) begin
                    w_state_nxt = START;
                end
            end
            START: begin
                w_cnt_run = 1'b1;
                if (r_cnt == HALF_END) begin
                    if (w_rxd_s) begin
                        w_state_nxt = IDLE;
                    end else begin
                        w_state_nxt  = DATA;
                        w_enter_data = 1'b1;
                    end
                end
            end
            DATA: begin
                w_cnt_run = 1'b1;
                if (r_cnt == BIT_END) begin
                    w_shift_en = 1'b1;
                    if (r_idx == 3'd7) begin
                        w_state_nxt = STOP;
                    end
                end
            end
            STOP: begin
                w_cnt_run = 1'b1;
                if (r_cnt == BIT_END) begin
                    if (w_rxd_s) begin
                        w_stop_ok   = 1'b1;
                        w_state_nxt = IDLE;
                    end else begin
                        w_stop_bad  = 1'b1;
                        w_state_nxt = BREAK;
                    end
                end
            end
            BREAK: begin
                if (w_rxd_s) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
        // Every bit sample restarts the bit timer, as does every state change.
        w_cnt_clr = (w_state_nxt != r_state) || w_shift_en;
    end

    // Bit timer, bit index and shift register.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_cnt   <= '0;
            r_idx   <= '0;
            r_shift <= '0;
        end else begin
            if (w_cnt_clr || !w_cnt_run) begin
                r_cnt <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
            if (w_enter_data) begin
                r_idx <= '0;
            end else if (w_shift_en) begin
                r_idx <= r_idx + 1'b1;
            end
            if (w_shift_en) begin
                r_shift[r_idx] <= w_rxd_s;
            end
        end
    end

    assign w_xfer = r_tvalid && rxbyte.tready;
    // A completed byte can only land if the holding register is empty or draining now.
    assign w_load = w_stop_ok && (!r_tvalid || rxbyte.tready);

    // Output holding register and one-cycle status pulses.
    always_ff @(posedge aclk) begin
        if (areset) begin
            r_tvalid      <= 1'b0;
            r_tdata       <= '0;
            r_frame_error <= 1'b0;
            r_overrun     <= 1'b0;
        end else begin
            r_frame_error <= w_stop_bad;
            r_overrun     <= w_stop_ok && !w_load;
            if (w_load) begin
                r_tdata  <= r_shift;
                r_tvalid <= 1'b1;
            end else if (w_xfer) begin
                r_tvalid <= 1'b0;
            end
        end
    end

    assign rxbyte.tvalid = r_tvalid;
    assign rxbyte.tdata  = r_tdata;
    assign frame_error   = r_frame_error;
    assign overrun       = r_overrun;
endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx with an ideal-rate line driver.
`timescale 1ns/1ps
module tb_uart_rx;
    localparam int N = 8;

    logic aclk     = 1'b0;
    logic areset   = 1'b1;
    logic uart_rxd = 1'b1;
    logic frame_error;
    logic overrun;

    uart_rx_if rxbyte_if ();

    uart_rx #(
        .CLKS_PER_BIT (N)
    ) dut (
        .aclk        (aclk),
        .areset      (areset),
        .uart_rxd    (uart_rxd),
        .rxbyte      (rxbyte_if),
        .frame_error (frame_error),
        .overrun     (overrun)
    );

    always #5 aclk = ~aclk;

    int n_checks = 0;
    int n_fail   = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // Observed beats and pulse counts; expected beats are filled in by the stimulus.
    logic [7:0] got_q[$];
    logic [7:0] exp_q[$];
    int         fe_cnt = 0;
    int         ov_cnt = 0;
    logic       prev_hold = 1'b0;
    logic       prev_rst  = 1'b1;
    logic [7:0] prev_data = 8'h00;

    // Inputs change on negedges only, so negedge+1 sees exactly what the next posedge will use.
    always begin
        @(negedge aclk);
        #1;
        if (!areset && !prev_rst && prev_hold) begin
            chk("hold_valid", rxbyte_if.tvalid, 1);
            chk("hold_data", rxbyte_if.tdata, prev_data);
        end
        if (!areset) begin
            if (rxbyte_if.tvalid && rxbyte_if.tready) got_q.push_back(rxbyte_if.tdata);
            if (frame_error) fe_cnt++;
            if (overrun) ov_cnt++;
            if (frame_error || overrun) chk("pulse_excl", frame_error & overrun, 0);
        end
        prev_hold = rxbyte_if.tvalid && !rxbyte_if.tready && !areset;
        prev_data = rxbyte_if.tdata;
        prev_rst  = areset;
    end

    // Drives the first n_slots bit slots of a character (slot 0 = start, 9 = stop).
    task automatic drive_frame(input logic [7:0] b, input logic stop_bit, input int n_slots);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int s = 0; s < n_slots; s++) begin
            uart_rxd = f[s];
            repeat (N) @(negedge aclk);
        end
    endtask

    task automatic line_idle(input int n);
        uart_rxd = 1'b1;
        repeat (n) @(negedge aclk);
    endtask

    task automatic check_beats(input string tag);
        chk({tag, "_count"}, got_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size() && i < got_q.size(); i++)
            chk({tag, "_data"}, got_q[i], exp_q[i]);
        got_q.delete();
        exp_q.delete();
    endtask

    task automatic check_pulses(input string tag, input int exp_fe, input int exp_ov);
        chk({tag, "_frame_err"}, fe_cnt, exp_fe);
        chk({tag, "_overrun"}, ov_cnt, exp_ov);
        fe_cnt = 0;
        ov_cnt = 0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int         exp_fe;
        logic [7:0] b;
        int         kind;

        rxbyte_if.tready = 1'b0;
        repeat (3) @(negedge aclk);
        #1;
        chk("rst_tvalid", rxbyte_if.tvalid, 0);
        chk("rst_tdata", rxbyte_if.tdata, 0);
        chk("rst_frame_err", frame_error, 0);
        chk("rst_overrun", overrun, 0);
        @(negedge aclk);
        areset = 1'b0;
        line_idle(4);

        // 1: single byte; counts edges from the first one that sees the low line
        // through the edge that raises tvalid (3 + N/2 + 9N = 79 for N=8).
        rxbyte_if.tready = 1'b1;
        fork
            drive_frame(8'hA5, 1'b1, 10);
            begin
                int n;
                n = 0;
                do begin
                    @(posedge aclk);
                    #1;
                    n++;
                end while (!rxbyte_if.tvalid && n < 200);
                chk("t1_latency", n, 79);
            end
        join
        exp_q.push_back(8'hA5);
        line_idle(2 * N);
        check_beats("t1");
        check_pulses("t1", 0, 0);

        // 2: back-to-back characters
        drive_frame(8'h00, 1'b1, 10);
        drive_frame(8'hFF, 1'b1, 10);
        drive_frame(8'h7D, 1'b1, 10);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'hFF);
        exp_q.push_back(8'h7D);
        line_idle(2 * N);
        check_beats("t2");
        check_pulses("t2", 0, 0);

        // 3: bad stop bit, line held low, then a good byte
        drive_frame(8'h55, 1'b0, 10);
        uart_rxd = 1'b0;
        repeat (30) @(negedge aclk);
        line_idle(2 * N);
        drive_frame(8'h3C, 1'b1, 10);
        exp_q.push_back(8'h3C);
        line_idle(2 * N);
        check_beats("t3");
        check_pulses("t3", 1, 0);

        // 4: short glitch on an idle line
        uart_rxd = 1'b0;
        repeat (2) @(negedge aclk);
        line_idle(2 * N);
        drive_frame(8'h12, 1'b1, 10);
        exp_q.push_back(8'h12);
        line_idle(2 * N);
        check_beats("t4");
        check_pulses("t4", 0, 0);

        // 5a: overrun while the first byte is still held
        rxbyte_if.tready = 1'b0;
        drive_frame(8'h11, 1'b1, 10);
        drive_frame(8'h22, 1'b1, 10);
        line_idle(2 * N);
        chk("t5a_held_valid", rxbyte_if.tvalid, 1);
        chk("t5a_held_data", rxbyte_if.tdata, 8'h11);
        check_pulses("t5a", 0, 1);
        rxbyte_if.tready = 1'b1;
        repeat (3) @(negedge aclk);
        rxbyte_if.tready = 1'b0;
        #1;
        chk("t5a_drained", rxbyte_if.tvalid, 0);
        @(negedge aclk);
        exp_q.push_back(8'h11);
        check_beats("t5a");

        // 5b: tready pulsed on the exact cycle the second byte loads
        drive_frame(8'h11, 1'b1, 10);
        line_idle(N);
        fork
            drive_frame(8'h22, 1'b1, 10);
            begin
                repeat (78) @(negedge aclk);
                rxbyte_if.tready = 1'b1;
                @(negedge aclk);
                rxbyte_if.tready = 1'b0;
            end
        join
        line_idle(2 * N);
        chk("t5b_held_valid", rxbyte_if.tvalid, 1);
        chk("t5b_held_data", rxbyte_if.tdata, 8'h22);
        check_pulses("t5b", 0, 0);
        rxbyte_if.tready = 1'b1;
        repeat (3) @(negedge aclk);
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        check_beats("t5b");

        // 6: reset mid-character while a byte is held; the held byte is discarded
        rxbyte_if.tready = 1'b0;
        drive_frame(8'h5A, 1'b1, 10);
        line_idle(2 * N);
        chk("t6_pre_valid", rxbyte_if.tvalid, 1);
        drive_frame(8'h81, 1'b1, 5);
        uart_rxd = 1'b0;
        areset   = 1'b1;
        @(negedge aclk);
        areset   = 1'b0;
        uart_rxd = 1'b1;
        #1;
        chk("t6_rst_tvalid", rxbyte_if.tvalid, 0);
        chk("t6_rst_tdata", rxbyte_if.tdata, 0);
        chk("t6_rst_frame_err", frame_error, 0);
        chk("t6_rst_overrun", overrun, 0);
        line_idle(3 * N);
        chk("t6_no_beat", rxbyte_if.tvalid, 0);
        rxbyte_if.tready = 1'b1;
        drive_frame(8'h81, 1'b1, 10);
        exp_q.push_back(8'h81);
        line_idle(2 * N);
        check_beats("t6");
        check_pulses("t6", 0, 0);

        // 7: random mix of good characters, framing errors and glitches
        exp_fe = 0;
        for (int i = 0; i < 24; i++) begin
            b    = 8'($urandom_range(0, 255));
            kind = $urandom_range(0, 4);
            if (kind == 0) begin
                uart_rxd = 1'b0;
                repeat ($urandom_range(1, 2)) @(negedge aclk);
                line_idle(12);
                drive_frame(b, 1'b1, 10);
                exp_q.push_back(b);
                line_idle($urandom_range(0, 6));
            end else if (kind == 1) begin
                drive_frame(b, 1'b0, 10);
                exp_fe++;
                line_idle($urandom_range(4, 12));
            end else begin
                drive_frame(b, 1'b1, 10);
                exp_q.push_back(b);
                line_idle($urandom_range(0, 6));
            end
        end
        line_idle(2 * N);
        check_beats("t7");
        check_pulses("t7", exp_fe, 0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end
endmodule

// File: doc/uart_rx.md
# uart_rx

Asynchronous serial receiver producing the AXI4-Stream byte stream consumed by the receive path of the framing block (its `rxbyte` target). It oversamples the UART line with `aclk` and samples each bit at mid-period. Each good 8N1 character becomes one single-beat AXI4-Stream transfer. Framing errors and overruns are reported as one-cycle pulses; the offending byte is dropped.

## Interface
- `CLKS_PER_BIT`, default 868 — `aclk` cycles per bit (100 MHz / 115200); legal range ≥ 4; odd values truncate the half-bit to `CLKS_PER_BIT/2`.
- `aclk`  in  1  clock; all logic rising-edge.
- `areset`  in  1  reset, synchronous, active-high.
- `uart_rxd`  in  1  asynchronous serial line; idle high.
- `rxbyte_tvalid`  out  1  output byte valid.
- `rxbyte_tready`  in  1  downstream ready.
- `rxbyte_tdata`  out  8  received byte, LSB first on the line.
- `frame_error`  out  1  one-cycle pulse: stop bit sampled low.
- `overrun`  out  1  one-cycle pulse: byte completed while the output register was still held.

## Operation
- **Synchronizer:** `uart_rxd` passes through 2 flops (`rxd_s`), which reset to 1.
- **Bit counter:** `cnt`, width `$clog2(CLKS_PER_BIT)`. It clears on every state change and every bit sample. Bit index `idx` is 3 bits wide.
- **State machine:**
  - IDLE: when `rxd_s`=0, go to START.
  - START: at `cnt`=`CLKS_PER_BIT/2`−1, sample. If 0, go to DATA with `idx`=0. If 1 (glitch), return to IDLE with no output and no error.
  - DATA: at `cnt`=`CLKS_PER_BIT`−1, shift `rxd_s` into bit `idx` of the shift register. After `idx`=7, go to STOP.
  - STOP: at `cnt`=`CLKS_PER_BIT`−1, sample. If 1, deliver the byte (see below) and go to IDLE. If 0, pulse `frame_error`, drop the byte and go to BREAK.
  - BREAK: wait for `rxd_s`=1, then go to IDLE. This prevents a held-low line from retriggering.
- **Delivery** at a good stop sample:
  - If `rxbyte_tvalid`=0, or `rxbyte_tvalid`=1 and `rxbyte_tready`=1 in the same cycle: load `rxbyte_tdata` and set `rxbyte_tvalid` next cycle.
  - Otherwise keep the held byte unchanged, drop the new one and pulse `overrun`.
- **Handshake:**
  - `rxbyte_tvalid`, once high, stays high and `rxbyte_tdata` stays stable until `tvalid && tready`.
  - The cycle after a transfer, `tvalid` goes to 0 unless a new byte loads in that same cycle.
- **Line activity:** the line is never back-pressured. Reception continues regardless of `tready`.
- **Reset:**
  - Sync flops go to 1, FSM to IDLE, `cnt`/`idx`/shift register to 0.
  - `rxbyte_tvalid`=0, `rxbyte_tdata`=0, `frame_error`=0, `overrun`=0.
  - Reset asserted mid-character abandons it. After release, reception resumes at the next low seen in IDLE; a line still low after release is treated as a start bit.

## Timing
- **Latency:** from the first `aclk` edge at which `uart_rxd` is sampled low to `rxbyte_tvalid` high is exactly 3 + `CLKS_PER_BIT/2` + 9·`CLKS_PER_BIT` cycles. For `CLKS_PER_BIT`=8 this is 79.
- **Error pulses:** `frame_error` and `overrun` rise the cycle after the stop sample, last exactly one cycle, and are mutually exclusive.
- **Throughput:** back-to-back characters with a one-bit stop are received without loss when `tready`=1. The FSM reaches IDLE at mid stop bit, ½ bit before the next start edge.
- **Baud tolerance:** ≥ ±3 % mismatch between `CLKS_PER_BIT` and the actual line rate is tolerated.

## Structure
- **`uart_pkg`:** holds the `state_t` enum (IDLE, START, DATA, STOP, BREAK) and the default `CLKS_PER_BIT` constant.
- **Sub-module `sync_2ff`:** a generic single-bit 2-flop synchronizer with reset value parameter `RST_VAL`=1. It is reused elsewhere.
- **Top-level:** `uart_rx` holds the FSM, counters, shift register and output register.

## Test plan
All scenarios use `CLKS_PER_BIT`=8 with an ideal-rate line model.
1. Send 0xA5 with `tready`=1 → one beat, `tdata`=0xA5, `tvalid` rises exactly 79 cycles after the start edge, no error pulses.
2. Send 0x00, 0xFF, 0x7D back-to-back with `tready`=1 → three beats in order, no drops, no pulses.
3. Send 0x55 with stop bit 0, hold the line low 30 cycles, release, then send 0x3C → single `frame_error` pulse, no beat for 0x55, then one beat 0x3C.
4. Drive a 2-cycle low glitch on an idle line, then send 0x12 → no beat and no pulse for the glitch, then one beat 0x12.
5. Overrun handling, with `tready`=0:
   - Send 0x11 then 0x22 → `tvalid` held with 0x11, `overrun` pulses at the 0x22 stop sample; raising `tready` delivers only 0x11.
   - Repeat with `tready` pulsed exactly on the 0x22 load cycle → 0x11 then 0x22 delivered, no overrun.
6. Assert `areset` for 1 cycle during DATA bit 4 of 0x81 → all outputs 0 the next cycle, no beat. After an idle line, send 0x81 → one beat 0x81.
